button_event_decoder: RTL and testbench

//  Consumes the debounced, clock-synchronous level from the button debouncer.

---
 rtl/button_event_decoder.sv | 208 ++++++++++++++++++++
 tb/tb_button_event_decoder.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_event_decoder.sv
// -----------------------------------------------------------------------------
// button_event_decoder
//
// Turns the debounced, clock-synchronous button level into single-cycle event
// pulses so that downstream control/UI logic never has to time hold periods
// itself. Every output is registered and is high for exactly one cycle.
//
// Events:
//   o_press   - rising edge of the button level
//   o_release - falling edge of the button level
//   o_long    - button held LONG_TICKS cycles since the press
//   o_short   - single click confirmed: no second press within DOUBLE_TICKS
//               cycles of the release
//   o_double  - second press within DOUBLE_TICKS cycles of the first release
//   o_repeat  - auto-repeat pulse every REPEAT_TICKS cycles while long-held
//
// Optional feature (compile-time macro):
//   AUTO_REPEAT_EN - when defined, the LONG state counts REPEAT_TICKS periods
//                    and pulses o_repeat; when undefined o_repeat stays 0,
//                    the LONG timer is held at 0 and REPEAT_TICKS is ignored.
//
// Parameters:
//   LONG_TICKS   - cycles held (from press) before o_long fires, >= 2
//   DOUBLE_TICKS - max cycles from release to second press for o_double, >= 2
//   REPEAT_TICKS - auto-repeat period in cycles, >= 2
//   TIMER_W      - timer width, must hold max(LONG,DOUBLE,REPEAT)_TICKS-1
//
// Ports:
//   i_clk      in   system clock, rising edge
//   i_rst_n    in   asynchronous, active-low reset
//   i_btn      in   debounced level, synchronous to i_clk, 1 = pressed
//   o_press    out  1-cycle pulse on press edge
//   o_release  out  1-cycle pulse on release edge
//   o_short    out  1-cycle pulse, single click confirmed
//   o_long     out  1-cycle pulse, held LONG_TICKS cycles
//   o_double   out  1-cycle pulse, second press inside the double window
//   o_repeat   out  1-cycle auto-repeat pulse while long-held
// -----------------------------------------------------------------------------
module button_event_decoder #(
  parameter int LONG_TICKS   = 20_000_000,
  parameter int DOUBLE_TICKS = 6_000_000,
  parameter int REPEAT_TICKS = 5_000_000,
  parameter int TIMER_W      = 25
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_press,
  output logic o_release,
  output logic o_short,
  output logic o_long,
  output logic o_double,
  output logic o_repeat
);

  // Elaboration-time sanity checks on the configuration.
  if (LONG_TICKS < 2 || DOUBLE_TICKS < 2 || REPEAT_TICKS < 2) begin : g_bad_ticks
    $error("button_event_decoder: all *_TICKS parameters must be >= 2");
  end

  if ((longint'(LONG_TICKS)   - 1) >= (longint'(1) << TIMER_W) ||
      (longint'(DOUBLE_TICKS) - 1) >= (longint'(1) << TIMER_W) ||
      (longint'(REPEAT_TICKS) - 1) >= (longint'(1) << TIMER_W)) begin : g_bad_timer_w
    $error("button_event_decoder: TIMER_W too narrow for the *_TICKS parameters");
  end

  // Terminal counts: the timer starts at 0 on entry to a counting state, so
  // the N-th edge spent in that state sees timer == N-1.
  localparam logic [TIMER_W-1:0] LONG_LAST   = TIMER_W'(LONG_TICKS - 1);
  localparam logic [TIMER_W-1:0] DOUBLE_LAST = TIMER_W'(DOUBLE_TICKS - 1);
`ifdef AUTO_REPEAT_EN
  localparam logic [TIMER_W-1:0] REPEAT_LAST = TIMER_W'(REPEAT_TICKS - 1);
`endif

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,  // released, nothing pending
    ST_PRESSED = 3'd1,  // first press, timing towards a long press
    ST_LONG    = 3'd2,  // long press reported, waiting for release
    ST_WAIT2   = 3'd3,  // released after a short hold, double-click window
    ST_HELD2   = 3'd4   // second press of a double click, waiting for release
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [TIMER_W-1:0]   timer;
  logic [TIMER_W-1:0]   timer_nxt;

  // Previous-cycle button sample used for edge detection.
  logic                 btn_p1;
  logic                 rise;
  logic                 fall;

  logic                 short_nxt;
  logic                 long_nxt;
  logic                 double_nxt;
  logic                 repeat_nxt;

  assign rise = i_btn & ~btn_p1;
  assign fall = ~i_btn & btn_p1;

  // ---------------------------------------------------------------------------
  // Next-state, timer and event decode
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt  = state;
    timer_nxt  = timer;
    short_nxt  = 1'b0;
    long_nxt   = 1'b0;
    double_nxt = 1'b0;
    repeat_nxt = 1'b0;

    case (state)
      ST_IDLE: begin
        timer_nxt = '0;
        if (rise) begin
          state_nxt = ST_PRESSED;
        end
      end

      ST_PRESSED: begin
        // A release on the terminal edge wins over the long-press report.
        if (fall) begin
          state_nxt = ST_WAIT2;
        end else if (timer == LONG_LAST) begin
          long_nxt  = 1'b1;
          state_nxt = ST_LONG;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end

      ST_LONG: begin
        if (fall) begin
          state_nxt = ST_IDLE;
        end else begin
`ifdef AUTO_REPEAT_EN
          if (i_btn && (timer == REPEAT_LAST)) begin
            repeat_nxt = 1'b1;
            timer_nxt  = '0;
          end else begin
            timer_nxt  = timer + 1'b1;
          end
`else
          timer_nxt = '0;
`endif
        end
      end

      ST_WAIT2: begin
        // A second press on the terminal edge wins over the short-click report.
        if (rise) begin
          double_nxt = 1'b1;
          state_nxt  = ST_HELD2;
        end else if (timer == DOUBLE_LAST) begin
          short_nxt  = 1'b1;
          state_nxt  = ST_IDLE;
        end else begin
          timer_nxt  = timer + 1'b1;
        end
      end

      ST_HELD2: begin
        timer_nxt = '0;
        if (fall) begin
          state_nxt = ST_IDLE;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
        timer_nxt = '0;
      end
    endcase

    // Every state change restarts the timer from 0.
    if (state_nxt != state) begin
      timer_nxt = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // State, timer, edge register and registered event outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= ST_IDLE;
      timer     <= '0;
      btn_p1    <= 1'b0;
      o_press   <= 1'b0;
      o_release <= 1'b0;
      o_short   <= 1'b0;
      o_long    <= 1'b0;
      o_double  <= 1'b0;
      o_repeat  <= 1'b0;
    end else begin
      state     <= state_nxt;
      timer     <= timer_nxt;
      btn_p1    <= i_btn;
      o_press   <= rise;
      o_release <= fall;
      o_short   <= short_nxt;
      o_long    <= long_nxt;
      o_double  <= double_nxt;
      o_repeat  <= repeat_nxt;
    end
  end

endmodule

// File: tb/tb_button_event_decoder.sv
// -----------------------------------------------------------------------------
// tb_button_event_decoder
//
// Directed and randomized stimulus for button_event_decoder with
// LONG_TICKS=20, DOUBLE_TICKS=10, REPEAT_TICKS=5, TIMER_W=5. Every clock edge
// is compared against a timestamp-based reference model of button episodes;
// directed scenarios additionally check pulse counts and latencies.
// -----------------------------------------------------------------------------
module tb_button_event_decoder;

  localparam int LONG_T = 20;
  localparam int DBL_T  = 10;
  localparam int REP_T  = 5;
  localparam int TW     = 5;

`ifdef AUTO_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic i_clk   = 1'b0;
  logic i_rst_n = 1'b0;
  logic i_btn   = 1'b0;
  logic o_press, o_release, o_short, o_long, o_double, o_repeat;

  button_event_decoder #(
    .LONG_TICKS   (LONG_T),
    .DOUBLE_TICKS (DBL_T),
    .REPEAT_TICKS (REP_T),
    .TIMER_W      (TW)
  ) dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_btn     (i_btn),
    .o_press   (o_press),
    .o_release (o_release),
    .o_short   (o_short),
    .o_long    (o_long),
    .o_double  (o_double),
    .o_repeat  (o_repeat)
  );

  always #5 i_clk = ~i_clk;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  // Reference model: the episode phase plus the cycle at which it started.
  localparam int PH_IDLE  = 0;
  localparam int PH_HOLD  = 1;
  localparam int PH_LONG  = 2;
  localparam int PH_GAP   = 3;
  localparam int PH_HOLD2 = 4;

  logic m_prev;
  int   m_phase;
  int   m_mark;
  logic e_press, e_release, e_short, e_long, e_double, e_repeat;

  // Observed pulse bookkeeping for directed latency/count checks.
  int c_press, c_rel, c_short, c_long, c_double, c_repeat;
  int t_press, t_rel, t_short, t_long, t_double, t_rep_first;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s @cyc %0d: observed %b expected %b", tag, cyc, obs, exp);
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_prev    = 1'b0;
    m_phase   = PH_IDLE;
    m_mark    = 0;
    e_press   = 1'b0;
    e_release = 1'b0;
    e_short   = 1'b0;
    e_long    = 1'b0;
    e_double  = 1'b0;
    e_repeat  = 1'b0;
  endtask

  task automatic model_edge(input logic b);
    logic up, down;
    up        = b & ~m_prev;
    down      = ~b & m_prev;
    e_press   = up;
    e_release = down;
    e_short   = 1'b0;
    e_long    = 1'b0;
    e_double  = 1'b0;
    e_repeat  = 1'b0;
    case (m_phase)
      PH_IDLE:  if (up) begin m_phase = PH_HOLD; m_mark = cyc; end
      PH_HOLD: begin
        if (down) begin
          m_phase = PH_GAP; m_mark = cyc;
        end else if (cyc - m_mark == LONG_T) begin
          e_long = 1'b1; m_phase = PH_LONG; m_mark = cyc;
        end
      end
      PH_LONG: begin
        if (down) m_phase = PH_IDLE;
        else if (REP_EN && b && (cyc - m_mark == REP_T)) begin
          e_repeat = 1'b1; m_mark = cyc;
        end
      end
      PH_GAP: begin
        if (up) begin
          e_double = 1'b1; m_phase = PH_HOLD2;
        end else if (cyc - m_mark == DBL_T) begin
          e_short = 1'b1; m_phase = PH_IDLE;
        end
      end
      default:  if (down) m_phase = PH_IDLE;
    endcase
    m_prev = b;
  endtask

  task automatic clear_counts();
    c_press = 0; c_rel = 0; c_short = 0; c_long = 0; c_double = 0; c_repeat = 0;
    t_press = -1; t_rel = -1; t_short = -1; t_long = -1; t_double = -1; t_rep_first = -1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_press"},   o_press,   1'b0);
    chk({tag, "_release"}, o_release, 1'b0);
    chk({tag, "_short"},   o_short,   1'b0);
    chk({tag, "_long"},    o_long,    1'b0);
    chk({tag, "_double"},  o_double,  1'b0);
    chk({tag, "_repeat"},  o_repeat,  1'b0);
  endtask

  // One clock edge with the given button level, checked against the model.
  task automatic tick(input logic b);
    i_btn = b;
    @(posedge i_clk);
    cyc++;
    model_edge(b);
    #1;
    chk("press",   o_press,   e_press);
    chk("release", o_release, e_release);
    chk("short",   o_short,   e_short);
    chk("long",    o_long,    e_long);
    chk("double",  o_double,  e_double);
    chk("repeat",  o_repeat,  e_repeat);
    chk("exclusive", ((32'(o_short) + 32'(o_long) + 32'(o_double) + 32'(o_repeat)) <= 1), 1'b1);
    if (o_press)   begin c_press++;  t_press  = cyc; end
    if (o_release) begin c_rel++;    t_rel    = cyc; end
    if (o_short)   begin c_short++;  t_short  = cyc; end
    if (o_long)    begin c_long++;   t_long   = cyc; end
    if (o_double)  begin c_double++; t_double = cyc; end
    if (o_repeat)  begin
      if (c_repeat == 0) t_rep_first = cyc;
      c_repeat++;
    end
  endtask

  task automatic run(input logic b, input int n);
    for (int i = 0; i < n; i++) tick(b);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    clear_counts();

    // Reset held while the button toggles: everything stays 0.
    for (int i = 0; i < 6; i++) begin
      i_btn = ~i_btn;
      @(posedge i_clk);
      #1;
      chk_all_zero("in_reset");
    end

    // Button held through reset release: first edge reports a press.
    i_btn = 1'b1;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    model_reset();
    tick(1'b1);
    chk("held_through_reset_press", o_press, 1'b1);
    run(1'b1, 3);
    run(1'b0, 15);

    // Short click: 5 high, then low.
    clear_counts();
    run(1'b1, 5);
    run(1'b0, 20);
    chk_int("short_n_press",   c_press, 1);
    chk_int("short_rel_lat",   t_rel - t_press, 5);
    chk_int("short_n_short",   c_short, 1);
    chk_int("short_lat",       t_short - t_rel, 10);
    chk_int("short_n_long",    c_long, 0);
    chk_int("short_n_double",  c_double, 0);

    // Long press: 30 high, then release gives no short.
    clear_counts();
    run(1'b1, 30);
    run(1'b0, 15);
    chk_int("long_n_long",     c_long, 1);
    chk_int("long_lat",        t_long - t_press, 20);
    chk_int("long_n_rel",      c_rel, 1);
    chk_int("long_n_short",    c_short, 0);
    chk_int("long_n_repeat",   c_repeat, REP_EN ? 1 : 0);

    // Long hold with auto-repeat: 41 high samples, repeats at +25/+30/+35/+40.
    clear_counts();
    run(1'b1, 41);
    run(1'b0, 15);
    chk_int("hold41_n_long",   c_long, 1);
    chk_int("hold41_n_repeat", c_repeat, REP_EN ? 4 : 0);
`ifdef AUTO_REPEAT_EN
    chk_int("repeat_first_lat", t_rep_first - t_long, 5);
`endif

    // Double click: high 3, low 4, high 3, low.
    clear_counts();
    run(1'b1, 3);
    run(1'b0, 4);
    run(1'b1, 3);
    run(1'b0, 15);
    chk_int("dbl_n_press",     c_press, 2);
    chk_int("dbl_n_double",    c_double, 1);
    chk_int("dbl_with_press",  t_double, t_press);
    chk_int("dbl_n_short",     c_short, 0);

    // Boundary: second rise on the 10th window edge is still a double.
    clear_counts();
    run(1'b1, 3);
    run(1'b0, 10);
    run(1'b1, 3);
    run(1'b0, 15);
    chk_int("win10_n_double",  c_double, 1);
    chk_int("win10_n_short",   c_short, 0);

    // One edge later: short first, then a fresh press.
    clear_counts();
    run(1'b1, 3);
    run(1'b0, 11);
    run(1'b1, 3);
    run(1'b0, 15);
    chk_int("win11_n_double",  c_double, 0);
    chk_int("win11_n_short",   c_short, 2);
    chk_int("win11_n_press",   c_press, 2);

    // Release on the long-press terminal edge: release wins.
    clear_counts();
    run(1'b1, 20);
    run(1'b0, 15);
    chk_int("simul_n_long",    c_long, 0);
    chk_int("simul_n_short",   c_short, 1);
    chk_int("simul_short_lat", t_short - t_rel, 10);

    // Asynchronous reset mid-press clears outputs at once, no later long.
    run(1'b0, 2);
    tick(1'b1);
    chk("pre_rst_press", o_press, 1'b1);
    #1 i_rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge i_clk);
      #1;
      chk_all_zero("rst_hold");
    end
    i_btn = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    clear_counts();
    run(1'b0, 30);
    chk_int("after_rst_n_long",  c_long, 0);
    chk_int("after_rst_n_press", c_press, 0);

    // Randomized hold/gap runs, every edge checked against the model.
    for (int r = 0; r < 80; r++) begin
      run(r[0] ? 1'b0 : 1'b1, int'($urandom_range(1, 26)));
    end
    run(1'b0, 15);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
